// File: rtl/extender_pkg.sv
// Shared datapath widths for immediate handling.
// The extender takes its default parameter values from here.
package extender_pkg;

    localparam int IMM_WIDTH  = 16;
    localparam int WORD_WIDTH = 32;

endpackage

// File: rtl/extender.sv
// Immediate extender: widens In to OUT_WIDTH by sign or zero extension.
// The output is either combinational or held in a register with synchronous reset.
module extender
    import extender_pkg::*;
#(
    parameter int IN_WIDTH   = IMM_WIDTH,
    parameter int OUT_WIDTH  = WORD_WIDTH,
    parameter bit REGISTERED = 1'b0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 SignExt,
    input  logic [IN_WIDTH-1:0]  In,
    output logic [OUT_WIDTH-1:0] Out
);

    generate
        if (OUT_WIDTH <= IN_WIDTH) begin : g_width_check
            $error("extender: OUT_WIDTH must be greater than IN_WIDTH");
        end
    endgenerate

    logic                 fill;
    logic [OUT_WIDTH-1:0] ext;

    // In zero-extend mode the fill bit is forced low. Otherwise it copies the input MSB.
    assign fill = SignExt & In[IN_WIDTH-1];
    assign ext  = {{(OUT_WIDTH-IN_WIDTH){fill}}, In};

    generate
        if (REGISTERED) begin : g_reg
            always_ff @(posedge Clock) begin
                if (Reset) Out <= '0;
                else       Out <= ext;
            end
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = Clock ^ Reset;
            assign Out = ext;
        end
    endgenerate

endmodule

// File: tb/tb_extender.sv
// Directed bench for extender.
// Table-driven checks on the combinational build, plus a hand sequence on the registered build.
module tb_extender;

    logic        clk = 1'b0;
    logic        rst_c = 1'b0;
    logic        se_c  = 1'b0;
    logic [15:0] in_c  = '0;
    logic [31:0] out_c;
    logic        rst_r = 1'b0;
    logic        se_r  = 1'b0;
    logic [15:0] in_r  = '0;
    logic [31:0] out_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    extender #(.IN_WIDTH(16), .OUT_WIDTH(32), .REGISTERED(1'b0)) u_comb (
        .Clock(clk), .Reset(rst_c), .SignExt(se_c), .In(in_c), .Out(out_c)
    );

    extender #(.IN_WIDTH(16), .OUT_WIDTH(32), .REGISTERED(1'b1)) u_reg (
        .Clock(clk), .Reset(rst_r), .SignExt(se_r), .In(in_r), .Out(out_r)
    );

    typedef struct {
        logic [15:0] in;
        logic        se;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        vec_t vecs [10];
        vecs[0] = '{16'h0001, 1'b0, 32'h0000_0001};
        vecs[1] = '{16'h0002, 1'b1, 32'h0000_0002};
        vecs[2] = '{16'hF000, 1'b1, 32'hFFFF_F000};
        vecs[3] = '{16'hF000, 1'b0, 32'h0000_F000};
        vecs[4] = '{16'h7000, 1'b1, 32'h0000_7000};
        vecs[5] = '{16'h8000, 1'b1, 32'hFFFF_8000};
        vecs[6] = '{16'hFFFF, 1'b0, 32'h0000_FFFF};
        vecs[7] = '{16'hFFFF, 1'b1, 32'hFFFF_FFFF};
        vecs[8] = '{16'h7FFF, 1'b1, 32'h0000_7FFF};
        vecs[9] = '{16'h0000, 1'b1, 32'h0000_0000};

        // The combinational build must ignore Reset.
        rst_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_c = vecs[i].in;
            se_c = vecs[i].se;
            #1;
            check($sformatf("comb_vec%0d", i), out_c, vecs[i].exp);
        end
        rst_c = 1'b0;

        // Registered build: reset on one edge.
        @(negedge clk);
        rst_r = 1'b1; in_r = 16'h0000; se_r = 1'b0;
        @(posedge clk); #1;
        check("reg_reset", out_r, 32'h0000_0000);

        // New input holds until the next edge, then appears.
        @(negedge clk);
        rst_r = 1'b0; in_r = 16'hF000; se_r = 1'b1;
        #1;
        check("reg_hold_before_edge", out_r, 32'h0000_0000);
        @(posedge clk); #1;
        check("reg_capture_f000", out_r, 32'hFFFF_F000);

        // When both are active on the same edge, reset wins over capture.
        @(negedge clk);
        rst_r = 1'b1; in_r = 16'h1234; se_r = 1'b0;
        @(posedge clk); #1;
        check("reg_reset_wins", out_r, 32'h0000_0000);

        @(negedge clk);
        rst_r = 1'b0;
        @(posedge clk); #1;
        check("reg_capture_1234", out_r, 32'h0000_1234);

        // A reset pulse that falls between edges has no effect.
        @(negedge clk);
        rst_r = 1'b1;
        #1;
        check("reg_midcycle_reset", out_r, 32'h0000_1234);
        #1;
        rst_r = 1'b0; in_r = 16'h8000; se_r = 1'b1;
        @(posedge clk); #1;
        check("reg_capture_8000", out_r, 32'hFFFF_8000);

        @(negedge clk);
        in_r = 16'hFFFF; se_r = 1'b0;
        @(posedge clk); #1;
        check("reg_capture_ffff_zext", out_r, 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
